// File: rtl/filter_memory_pkg.sv
// Shared constants and the loader state type for the filter memory writer and reader.
package filter_memory_pkg;

  localparam int unsigned ELEMENT_WIDTH       = 16;
  localparam int unsigned ELEMENTS_PER_VECTOR = 16;
  localparam int unsigned NUM_B_VECTORS       = 4;
  localparam int unsigned FILTER_ADDR_WIDTH   = 9;

  // Derived index widths: element within a vector, vector within a filter, whole filter.
  localparam int unsigned ELEMENT_INDEX_WIDTH = $clog2(ELEMENTS_PER_VECTOR);
  localparam int unsigned VECTOR_INDEX_WIDTH  = $clog2(NUM_B_VECTORS);
  localparam int unsigned FILTER_INDEX_WIDTH  = ELEMENT_INDEX_WIDTH + VECTOR_INDEX_WIDTH;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StFinish
  } loader_state_e;

endpackage

// File: rtl/filter_load_index_counter.sv
// Element/vector index counter for one filter, vector-major order.
module filter_load_index_counter
  import filter_memory_pkg::*;
(
  input  logic                           clk_i,
  input  logic                           clear_ni,
  input  logic                           clr_i,
  input  logic                           incr_i,
  output logic [ELEMENT_INDEX_WIDTH-1:0] element_index_o,
  output logic [VECTOR_INDEX_WIDTH-1:0]  vector_index_o,
  output logic                           last_element_o
);

  logic [ELEMENT_INDEX_WIDTH-1:0] element_index_d, element_index_q;
  logic [VECTOR_INDEX_WIDTH-1:0]  vector_index_d, vector_index_q;

  // Next index: clear wins over increment; vector advances when element wraps to 0.
  always_comb begin
    element_index_d = element_index_q;
    vector_index_d  = vector_index_q;
    if (clr_i) begin
      element_index_d = '0;
      vector_index_d  = '0;
    end else if (incr_i) begin
      element_index_d = element_index_q + 1'b1;
      if (&element_index_q) begin
        vector_index_d = vector_index_q + 1'b1;
      end
    end
  end

  // Index registers with synchronous active-low clear.
  always_ff @(posedge clk_i) begin
    if (!clear_ni) begin
      element_index_q <= '0;
      vector_index_q  <= '0;
    end else begin
      element_index_q <= element_index_d;
      vector_index_q  <= vector_index_d;
    end
  end

  assign element_index_o = element_index_q;
  assign vector_index_o  = vector_index_q;
  assign last_element_o  = (&element_index_q) && (&vector_index_q);

endmodule

// File: rtl/filter_memory_loader.sv
// Writer side of the filter memory: streams 64 elements into a vector-major filter slot.
// Optional feature: define FILTER_LOADER_CHECKSUM_EN for a running 16-bit element sum.
module filter_memory_loader
  import filter_memory_pkg::*;
#(
  parameter int unsigned BASE_ADDRESS = 0
) (
  input  logic                         clock,
  input  logic                         clear_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [ELEMENT_WIDTH-1:0]     in_element,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [FILTER_ADDR_WIDTH-1:0] memory_address,
  output logic [ELEMENT_WIDTH-1:0]     memory_data,
  output logic                         memory_enable,
  output logic                         memory_write,
  output logic                         busy,
  output logic                         load_done,
  output logic                         filter_loaded,
  output logic [ELEMENT_WIDTH-1:0]     checksum
);

  // Only the upper bits of the base take part; the in-filter index fills the low bits,
  // so the index can never carry into the base.
  localparam int unsigned BASE_WIDTH = FILTER_ADDR_WIDTH - FILTER_INDEX_WIDTH;
  localparam logic [BASE_WIDTH-1:0] BaseHi = BASE_WIDTH'(BASE_ADDRESS >> FILTER_INDEX_WIDTH);

  loader_state_e                  state_q;
  logic [FILTER_ADDR_WIDTH-1:0]   memory_address_q;
  logic [ELEMENT_WIDTH-1:0]       memory_data_q;
  logic                           memory_write_q;
  logic                           load_done_q;
  logic                           filter_loaded_q;

  logic [ELEMENT_INDEX_WIDTH-1:0] element_index;
  logic [VECTOR_INDEX_WIDTH-1:0]  vector_index;
  logic                           last_element;
  logic                           start_honoured;
  logic                           accept;

  // Handshake and control decode; abort suppresses acceptance in the same cycle.
  always_comb begin
    in_ready       = (state_q == StLoad);
    busy           = (state_q != StIdle);
    start_honoured = (state_q == StIdle) && start;
    accept         = in_ready && in_valid && !abort;
  end

  filter_load_index_counter u_index_counter (
    .clk_i           (clock),
    .clear_ni        (clear_n),
    .clr_i           (start_honoured),
    .incr_i          (accept),
    .element_index_o (element_index),
    .vector_index_o  (vector_index),
    .last_element_o  (last_element)
  );

  // Loader FSM with registered write port and status outputs.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_q          <= StIdle;
      memory_address_q <= '0;
      memory_data_q    <= '0;
      memory_write_q   <= 1'b0;
      load_done_q      <= 1'b0;
      filter_loaded_q  <= 1'b0;
    end else begin
      memory_write_q <= accept;
      load_done_q    <= 1'b0;
      if (accept) begin
        memory_address_q <= {BaseHi, vector_index, element_index};
        memory_data_q    <= in_element;
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q         <= StLoad;
            filter_loaded_q <= 1'b0;
          end
        end
        StLoad: begin
          if (abort) begin
            state_q <= StIdle;
          end else if (accept && last_element) begin
            state_q         <= StFinish;
            load_done_q     <= 1'b1;
            filter_loaded_q <= 1'b1;
          end
        end
        StFinish: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign memory_address = memory_address_q;
  assign memory_data    = memory_data_q;
  assign memory_write   = memory_write_q;
  assign memory_enable  = memory_write_q;
  assign load_done      = load_done_q;
  assign filter_loaded  = filter_loaded_q;

`ifdef FILTER_LOADER_CHECKSUM_EN
  logic [ELEMENT_WIDTH-1:0] checksum_q;

  // Wrapping sum of accepted elements; cleared by reset or an honoured start.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      checksum_q <= '0;
    end else if (start_honoured) begin
      checksum_q <= '0;
    end else if (accept) begin
      checksum_q <= checksum_q + in_element;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_filter_memory_loader.sv
// Directed bench for filter_memory_loader: two instances (base 0 and base 128) share stimulus.
module tb_filter_memory_loader;

  logic        clock = 1'b0;
  logic        clear_n;
  logic        start;
  logic        abort;
  logic [15:0] in_element;
  logic        in_valid;

  logic        rdy [2];
  logic [8:0]  ma  [2];
  logic [15:0] md  [2];
  logic        me  [2];
  logic        mw  [2];
  logic        bsy [2];
  logic        ld  [2];
  logic        fl  [2];
  logic [15:0] cks [2];

  int n_checks = 0;
  int n_errors = 0;

  int wr_cnt   [2];
  int ld_cnt   [2];
  int bad_data [2];
  int hits     [2][512];

`ifdef FILTER_LOADER_CHECKSUM_EN
  localparam logic [15:0] ExpSum = 16'd2016;
`else
  localparam logic [15:0] ExpSum = 16'd0;
`endif

  always #5 clock = ~clock;

  filter_memory_loader #(.BASE_ADDRESS(0)) dut0 (
    .clock(clock), .clear_n(clear_n), .start(start), .abort(abort),
    .in_element(in_element), .in_valid(in_valid), .in_ready(rdy[0]),
    .memory_address(ma[0]), .memory_data(md[0]), .memory_enable(me[0]),
    .memory_write(mw[0]), .busy(bsy[0]), .load_done(ld[0]),
    .filter_loaded(fl[0]), .checksum(cks[0])
  );

  filter_memory_loader #(.BASE_ADDRESS(128)) dut1 (
    .clock(clock), .clear_n(clear_n), .start(start), .abort(abort),
    .in_element(in_element), .in_valid(in_valid), .in_ready(rdy[1]),
    .memory_address(ma[1]), .memory_data(md[1]), .memory_enable(me[1]),
    .memory_write(mw[1]), .busy(bsy[1]), .load_done(ld[1]),
    .filter_loaded(fl[1]), .checksum(cks[1])
  );

  function automatic int base_of(input int k);
    return (k == 0) ? 0 : 128;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Memory-side scoreboard: every write lands here, data must equal the address offset.
  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (mw[k] === 1'b1) begin
        wr_cnt[k]++;
        hits[k][ma[k]]++;
        if (md[k] !== 16'(int'(ma[k]) - base_of(k))) bad_data[k]++;
      end
      if (ld[k] === 1'b1) ld_cnt[k]++;
    end
  end

  task automatic clear_sb();
    for (int k = 0; k < 2; k++) begin
      wr_cnt[k] = 0;
      ld_cnt[k] = 0;
      bad_data[k] = 0;
      for (int a = 0; a < 512; a++) hits[k][a] = 0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      check({tag, "_in_ready"}, rdy[k], 0);
      check({tag, "_busy"}, bsy[k], 0);
      check({tag, "_addr"}, ma[k], 0);
      check({tag, "_data"}, md[k], 0);
      check({tag, "_enable"}, me[k], 0);
      check({tag, "_write"}, mw[k], 0);
      check({tag, "_load_done"}, ld[k], 0);
      check({tag, "_loaded"}, fl[k], 0);
      check({tag, "_checksum"}, cks[k], 0);
    end
  endtask

  task automatic pulse_start(input string tag);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check({tag, "_busy_rise"}, bsy[0], 1);
    check({tag, "_loaded_clr"}, fl[0], 0);
  endtask

  // Drive elements 0..63 (value = index). Optional abort / start / clear injection points.
  task automatic do_load(input string tag, input bit toggle, input int abort_at,
                         input int start_mid, input bit start_fin, input int clear_at);
    int acc = 0;
    int cyc = 0;
    int strobe_err = 0;
    bit v;
    while (acc < 64 && cyc < 400) begin
      v = toggle ? (cyc % 2 == 0) : 1'b1;
      in_valid   = v;
      in_element = 16'(acc);
      start      = (acc == start_mid);
      if (acc == abort_at) begin
        abort    = 1'b1;
        in_valid = 1'b1;
        @(posedge clock); #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        check({tag, "_abort_no_write"}, mw[0], 0);
        check({tag, "_abort_idle"}, bsy[0], 0);
        check({tag, "_abort_loaded"}, fl[0], 0);
        return;
      end
      if (acc == clear_at) begin
        clear_n = 1'b0;
        @(posedge clock); #1;
        check_all_zero({tag, "_clr"});
        clear_n  = 1'b1;
        in_valid = 1'b0;
        start    = 1'b0;
        return;
      end
      @(posedge clock); #1;
      cyc++;
      if (mw[0] !== v || me[0] !== v || mw[1] !== v || me[1] !== v) strobe_err++;
      if (v) begin
        if (acc == 0) begin
          check({tag, "_first_addr0"}, ma[0], 0);
          check({tag, "_first_addr1"}, ma[1], 128);
        end
        acc++;
      end
    end
    start    = 1'b0;
    in_valid = 1'b0;
    check({tag, "_accepted"}, acc, 64);
    check({tag, "_strobe"}, strobe_err, 0);
    check({tag, "_done_pulse"}, ld[0], 1);
    check({tag, "_ready_fin"}, rdy[0], 0);
    check({tag, "_last_write"}, mw[0], 1);
    check({tag, "_last_addr0"}, ma[0], 63);
    check({tag, "_last_addr1"}, ma[1], 191);
    check({tag, "_last_data"}, md[0], 63);
    if (start_fin) begin
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
    end
  endtask

  task automatic post_load(input string tag);
    int miss;
    int outside;
    repeat (3) @(posedge clock);
    #1;
    for (int k = 0; k < 2; k++) begin
      miss = 0;
      outside = 0;
      for (int a = 0; a < 512; a++) begin
        if (a >= base_of(k) && a < base_of(k) + 64) begin
          if (hits[k][a] != 1) miss++;
        end else if (hits[k][a] != 0) begin
          outside++;
        end
      end
      check({tag, "_writes"}, wr_cnt[k], 64);
      check({tag, "_addr_map"}, miss, 0);
      check({tag, "_outside"}, outside, 0);
      check({tag, "_data"}, bad_data[k], 0);
      check({tag, "_done_cnt"}, ld_cnt[k], 1);
      check({tag, "_loaded"}, fl[k], 1);
      check({tag, "_busy_low"}, bsy[k], 0);
      check({tag, "_checksum"}, cks[k], ExpSum);
    end
  endtask

  initial begin
    clear_n    = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    in_valid   = 1'b0;
    in_element = '0;
    clear_sb();
    repeat (2) @(posedge clock);
    #1;
    check_all_zero("reset");
    clear_n = 1'b1;
    @(posedge clock); #1;

    // Back-to-back full load.
    clear_sb();
    pulse_start("b2b");
    do_load("b2b", 1'b0, -1, -1, 1'b0, -1);
    post_load("b2b");

    // in_valid alternating for the whole load.
    clear_sb();
    pulse_start("tog");
    do_load("tog", 1'b1, -1, -1, 1'b0, -1);
    post_load("tog");

    // Abort after 20 accepts, then a clean restart.
    clear_sb();
    pulse_start("abt");
    do_load("abt", 1'b0, 20, -1, 1'b0, -1);
    repeat (3) @(posedge clock);
    #1;
    check("abt_writes", wr_cnt[0], 20);
    check("abt_no_done", ld_cnt[0], 0);
    check("abt_loaded", fl[0], 0);
    check("abt_ready", rdy[0], 0);
    clear_sb();
    pulse_start("abt_re");
    do_load("abt_re", 1'b0, -1, -1, 1'b0, -1);
    post_load("abt_re");

    // start during LOAD and during FINISH is ignored.
    clear_sb();
    pulse_start("ign");
    do_load("ign", 1'b0, -1, 30, 1'b1, -1);
    post_load("ign");

    // Reset mid-load, then a fresh full load.
    clear_sb();
    pulse_start("rst");
    do_load("rst", 1'b0, -1, -1, 1'b0, 40);
    @(posedge clock); #1;
    clear_sb();
    pulse_start("rst_re");
    do_load("rst_re", 1'b0, -1, -1, 1'b0, -1);
    post_load("rst_re");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
